// File: rtl/imem_port_ctrl_if.sv
// Bundle between loader/fetch/debug logic, the controller and the imem macro.
// Optional ld_csum output present when IMEM_LOAD_CSUM_EN is defined.
interface imem_port_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              ld_mode;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [15:0]       ld_count;
`ifdef IMEM_LOAD_CSUM_EN
  logic [DATA_W-1:0] ld_csum;
`endif
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic [DATA_W-1:0] if_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output ld_mode, ld_we, ld_addr, ld_wdata,
    output if_addr, dbg_req, dbg_addr, mem_rdata,
    input  ld_count, cpu_rst_n, if_stall, if_rdata,
    input  dbg_ack, dbg_rdata,
`ifdef IMEM_LOAD_CSUM_EN
    input  ld_csum,
`endif
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_mode, ld_we, ld_addr, ld_wdata,
    input  if_addr, dbg_req, dbg_addr, mem_rdata,
    output ld_count, cpu_rst_n, if_stall, if_rdata,
    output dbg_ack, dbg_rdata,
`ifdef IMEM_LOAD_CSUM_EN
    output ld_csum,
`endif
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_ctrl.sv
// imem_port_ctrl: owns the single imem port. HOLD/LOAD/RUN sequencing,
// loader writes, fetch reads, starvation-bounded debug reads.
// Ports: clk_i, rst_ni (async active-low), bus (imem_port_ctrl_if.slave).
// Optional IMEM_LOAD_CSUM_EN: bus.ld_csum = sum of loaded words.
module imem_port_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  imem_port_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [7:0] SMAX_M1 = 8'(STARVE_MAX - 1);

  state_e            state_q, state_d;
  logic              cpu_rst_n_q;
  logic              slot_q, slot_d;
  logic              ack_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       ld_count_q, ld_count_d;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              ld_wr;
`ifdef IMEM_LOAD_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign ld_wr = (state_q == LOAD) && bus.ld_we;

  always_comb begin
    state_d    = state_q;
    slot_d     = 1'b0;
    cnt_d      = cnt_q;
    ld_count_d = ld_count_q;
`ifdef IMEM_LOAD_CSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      HOLD: begin
        if (bus.ld_mode) begin
          state_d    = LOAD;
          ld_count_d = '0;
`ifdef IMEM_LOAD_CSUM_EN
          csum_d     = '0;
`endif
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (ld_wr) begin
          if (ld_count_q != 16'hFFFF)
            ld_count_d = ld_count_q + 16'd1;
`ifdef IMEM_LOAD_CSUM_EN
          csum_d = csum_q + bus.ld_wdata;
`endif
        end
        if (!bus.ld_mode) state_d = HOLD;
      end
      RUN: begin
        if (bus.ld_mode) state_d = HOLD;
        // A request being served (slot or ack) does not starve.
        if (bus.dbg_req) begin
          if (slot_q || ack_q) begin
            cnt_d = '0;
          end else if (cnt_q == SMAX_M1) begin
            // No slot when leaving RUN; counter holds for resume.
            if (!bus.ld_mode) begin
              slot_d = 1'b1;
              cnt_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
    if (!bus.dbg_req) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HOLD;
      cpu_rst_n_q <= 1'b0;
      slot_q      <= 1'b0;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      ld_count_q  <= '0;
      dbg_rdata_q <= '0;
`ifdef IMEM_LOAD_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= (state_d == RUN);
      slot_q      <= slot_d;
      ack_q       <= slot_q;
      cnt_q       <= cnt_d;
      ld_count_q  <= ld_count_d;
      if (ack_q) dbg_rdata_q <= bus.mem_rdata;
`ifdef IMEM_LOAD_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_stall  = 1'b1;
    unique case (1'b1)
      (state_q == LOAD): begin
        bus.mem_en    = bus.ld_we;
        bus.mem_we    = bus.ld_we;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_wdata;
      end
      (state_q == RUN): begin
        bus.mem_en   = 1'b1;
        bus.if_stall = slot_q;
        bus.mem_addr = slot_q ? bus.dbg_addr : bus.if_addr;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.ld_count  = ld_count_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dbg_ack   = ack_q;
  // Read data lands on mem_rdata in the ack cycle; hold it afterwards.
  assign bus.dbg_rdata = ack_q ? bus.mem_rdata : dbg_rdata_q;
`ifdef IMEM_LOAD_CSUM_EN
  assign bus.ld_csum   = csum_q;
`endif
endmodule

// File: tb/tb_imem_port_ctrl.sv
// Directed bench for imem_port_ctrl with a 1-cycle sync-read memory model.
// Checks reset, fetch, load, debug starvation slot, mode switch, reset abort.
module tb_imem_port_ctrl;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_ack = 0;

  logic [31:0] mem [0:16383];

  imem_port_ctrl_if #(.ADDR_W(14), .DATA_W(32)) bus ();

  imem_port_ctrl #(
    .ADDR_W(14), .DATA_W(32), .STARVE_MAX(8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
    if (bus.dbg_ack) n_ack <= n_ack + 1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_w(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = init_w(i);
    bus.mem_rdata = '0;
    bus.ld_mode = 0; bus.ld_we = 0;
    bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.if_addr = '0; bus.dbg_req = 0; bus.dbg_addr = '0;

    // reset state
    #12;
    chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    chk("rst_if_stall", 32'(bus.if_stall), 1);
    chk("rst_dbg_ack", 32'(bus.dbg_ack), 0);
    chk("rst_ld_count", 32'(bus.ld_count), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);

    // release: one cycle HOLD, then RUN
    step();
    rst_ni = 1;
    #1 chk("hold_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    chk("hold_mem_en", 32'(bus.mem_en), 0);
    step();
    chk("run_cpu_rst_n", 32'(bus.cpu_rst_n), 1);

    // fetch 0..2
    for (int i = 0; i < 3; i++) begin
      bus.if_addr = 14'(i);
      #1 chk("fetch_addr", 32'(bus.mem_addr), i);
      chk("fetch_stall", 32'(bus.if_stall), 0);
      chk("fetch_we", 32'(bus.mem_we), 0);
      step();
      chk("fetch_rdata", bus.if_rdata, init_w(i));
    end

    // enter LOAD via HOLD
    bus.ld_mode = 1;
    step();
    chk("ld_hold_cpu", 32'(bus.cpu_rst_n), 0);
    step();
    chk("ld_entry_cnt", 32'(bus.ld_count), 0);
    chk("ld_stall", 32'(bus.if_stall), 1);
    for (int k = 0; k < 3; k++) begin
      bus.ld_we = 1;
      bus.ld_addr = 14'(k);
      bus.ld_wdata = (k == 0) ? 32'h0050_0093 :
                     (k == 1) ? 32'h0010_0113 : 32'h0020_81B3;
      #1 chk("ld_mem_we", 32'(bus.mem_we), 1);
      chk("ld_mem_addr", 32'(bus.mem_addr), k);
      step();
    end
    bus.ld_we = 0;
    #1 chk("ld_idle_we", 32'(bus.mem_we), 0);
    chk("ld_count3", 32'(bus.ld_count), 3);
    bus.ld_mode = 0;
    step();
    chk("ld_exit_cpu", 32'(bus.cpu_rst_n), 0);
    step();
    chk("ld_run_cpu", 32'(bus.cpu_rst_n), 1);
    bus.if_addr = 14'd1;
    step();
    chk("ld_fetch1", bus.if_rdata, 32'h0010_0113);

    // debug starvation slot
    bus.if_addr = '0;
    bus.dbg_req = 1;
    bus.dbg_addr = 14'd2;
    for (int c = 0; c < 8; c++) begin
      #1 chk("dbg_no_stall", 32'(bus.if_stall), 0);
      step();
    end
    #1 chk("dbg_slot_stall", 32'(bus.if_stall), 1);
    chk("dbg_slot_addr", 32'(bus.mem_addr), 2);
    chk("dbg_slot_noack", 32'(bus.dbg_ack), 0);
    step();
    chk("dbg_ack", 32'(bus.dbg_ack), 1);
    chk("dbg_rdata", bus.dbg_rdata, 32'h0020_81B3);
    chk("dbg_after_stall", 32'(bus.if_stall), 0);
    step();
    bus.dbg_req = 0;
    #1 chk("dbg_ack_drop", 32'(bus.dbg_ack), 0);
    chk("dbg_rdata_hold", bus.dbg_rdata, 32'h0020_81B3);
    step();

    // ld_mode rises in the debug slot cycle
    bus.dbg_req = 1;
    bus.dbg_addr = 14'd1;
    for (int c = 0; c < 8; c++) step();
    bus.ld_mode = 1;
    #1 chk("sw_slot_stall", 32'(bus.if_stall), 1);
    step();
    chk("sw_ack", 32'(bus.dbg_ack), 1);
    chk("sw_rdata", bus.dbg_rdata, 32'h0010_0113);
    chk("sw_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    step();
    bus.dbg_req = 0;
    #1 chk("sw_ack_drop", 32'(bus.dbg_ack), 0);
    chk("sw_ld_count", 32'(bus.ld_count), 0);
    chk("sw_ack_total", 32'(n_ack), 2);

    // now in LOAD: two writes, then reset mid-load
    bus.ld_we = 1;
    bus.ld_addr = 14'd5;
    bus.ld_wdata = 32'h1111_2222;
    #1 chk("ab_load_we", 32'(bus.mem_we), 1);
    step();
    bus.ld_addr = 14'd6;
    bus.ld_wdata = 32'h3333_4444;
    step();
    chk("ab_count2", 32'(bus.ld_count), 2);
    bus.ld_addr = 14'd7;
    bus.ld_wdata = 32'hBAD0_BAD0;
    rst_ni = 0;
    #1 chk("ab_mem_en", 32'(bus.mem_en), 0);
    chk("ab_mem_we", 32'(bus.mem_we), 0);
    chk("ab_count", 32'(bus.ld_count), 0);
    chk("ab_cpu", 32'(bus.cpu_rst_n), 0);
    chk("ab_stall", 32'(bus.if_stall), 1);
    step();
    bus.ld_we = 0;
    bus.ld_mode = 0;
    rst_ni = 1;
    step();
    chk("ab_run", 32'(bus.cpu_rst_n), 1);
    for (int a = 5; a < 8; a++) begin
      bus.if_addr = 14'(a);
      step();
      chk("ab_readback", bus.if_rdata,
          (a == 5) ? 32'h1111_2222 :
          (a == 6) ? 32'h3333_4444 : init_w(7));
    end

`ifdef IMEM_LOAD_CSUM_EN
    bus.ld_mode = 1;
    step();
    step();
    chk("cs_clear", bus.ld_csum, 0);
    bus.ld_we = 1;
    bus.ld_addr = 14'd20;
    bus.ld_wdata = 32'hFFFF_FFFF;
    step();
    bus.ld_addr = 14'd21;
    bus.ld_wdata = 32'h0000_0002;
    step();
    bus.ld_we = 0;
    bus.ld_mode = 0;
    #1 chk("cs_sum", bus.ld_csum, 32'h0000_0001);
    step();
    step();
    chk("cs_hold_run", bus.ld_csum, 32'h0000_0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
